// File: rtl/line_rr_arbiter.sv
// line_rr_arbiter
//   Round-robin arbiter that shares one 2-to-4 line decoder among four
//   requesters. A grant lasts until the grantee drops its request or until
//   HOLD_MAX cycles have elapsed. One dead cycle separates any two grants,
//   so two decoder lines are never high at the same time.
//
//   State  | meaning
//   IDLE   | no grant, no requests pending
//   GRANT  | decoder enabled for requester sel; hold counter running
//   GAP    | single dead cycle after a grant; next winner is chosen here
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req[3:0] in   request vector, bit i from requester i
//   sel[1:0] out  registered grantee index, drives decoder in[1:0]
//   en       out  registered decoder enable, high only in GRANT
//   gnt[3:0] out  registered one-hot grant, en ? (1 << sel) : 0
//   expired  out  one-cycle pulse in a GAP caused by hold-time expiry
//   busy     out  high in GRANT and GAP
module line_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] gnt,
    output logic       expired,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic          en_q, en_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          expired_q, expired_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    logic [1:0] win_idx;
    logic [1:0] scan_idx;
    logic       win_found;

    // First asserted request scanning upward from ptr with 2-bit wrap.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        scan_idx  = ptr_q;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr_q + 2'(i);
            if (!win_found && req[scan_idx]) begin
                win_idx   = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        hold_cnt_d = hold_cnt_q;
        expired_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    sel_d      = win_idx;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                hold_cnt_d = hold_cnt_q + CW'(1);
                // Release is checked first so a grantee that lets go on its
                // last allowed cycle is not flagged as expired.
                if (!req[sel_q]) begin
                    state_d = ST_GAP;
                    ptr_d   = sel_q + 2'd1;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = ST_GAP;
                    ptr_d     = sel_q + 2'd1;
                    expired_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (win_found) begin
                    sel_d      = win_idx;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered copies of the next-state decode so they line up
    // with the state they describe.
    always_comb begin
        en_d   = (state_d == ST_GRANT);
        busy_d = (state_d != ST_IDLE);
        gnt_d  = en_d ? (4'b0001 << sel_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            sel_q      <= 2'd0;
            en_q       <= 1'b0;
            gnt_q      <= 4'b0000;
            expired_q  <= 1'b0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            gnt_q      <= gnt_d;
            expired_q  <= expired_d;
            busy_q     <= busy_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign sel     = sel_q;
    assign en      = en_q;
    assign gnt     = gnt_q;
    assign expired = expired_q;
    assign busy    = busy_q;

endmodule

// File: doc/line_rr_arbiter.md
Name: line_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2-to-4 line-decoder output stage among four requesters.
- Registers a 2-bit select and an enable to drive the decoder's `in[1:0]` and `en` inputs.
- Also provides the equivalent one-hot grant directly, so no requester depends on decoder timing.
- Bounds hold time per grant and inserts one dead cycle between grants so decoder lines never overlap.

Parameters:
- HOLD_MAX, 8: maximum consecutive GRANT cycles per grant; legal range 1..255.
- CW, 8: hold counter width; must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i asserted by requester i while it wants the line.
- sel  output  2  registered index of the current grantee; drives decoder `in[1:0]`.
- en  output  1  registered; high only in GRANT; drives decoder `en`.
- gnt  output  4  registered one-hot grant; equals `en ? (1<<sel) : 0`.
- expired  output  1  one-cycle pulse on the first cycle of a GAP that was caused by HOLD_MAX expiry.
- busy  output  1  high in GRANT and GAP.

Behaviour:
- Reset (rst_n low, asynchronous), all registers cleared:
  - state=IDLE, ptr=0, sel=0, en=0, gnt=0, expired=0, busy=0, hold_cnt=0.
  - Reset takes effect mid-grant as well; after release, arbitration restarts from ptr=0.
- All outputs come directly from registers; there is no combinational path from req to any output.
- Arbitration function (evaluated in IDLE and GAP):
  - Winner is the first asserted req bit scanning ptr, ptr+1, ptr+2, ptr+3, each index taken mod 4 (2-bit wrap, 3 -> 0).
- IDLE:
  - en=0, busy=0.
  - If req != 0 in cycle t: sel <= winner, hold_cnt <= 0, next state GRANT.
  - Result: gnt/en asserted in cycle t+1 (1-cycle latency).
  - If req == 0: stay in IDLE.
- GRANT:
  - en=1, gnt=onehot(sel), busy=1; hold_cnt increments by 1 each cycle.
  - Release: if req[sel]==0, next state GAP, expired stays 0.
  - Expiry: else if hold_cnt == HOLD_MAX-1, next state GAP and expired is 1 in the GAP cycle.
  - Release takes priority over expiry when both occur in the same cycle.
  - On either exit: ptr <= sel+1 mod 4.
  - Changes to other req bits during GRANT are ignored.
- GAP:
  - Exactly one cycle; en=0, gnt=0, busy=1.
  - Arbitration runs using the updated ptr.
  - If req != 0: sel <= winner, hold_cnt <= 0, next state GRANT.
  - Otherwise: next state IDLE and sel holds its value.
  - The previous grantee can win again only if no other requester is asserted.
- With HOLD_MAX=1, every grant is a single cycle followed by a GAP.
- Steady-state throughput with continuous contention is HOLD_MAX grant cycles per HOLD_MAX+1 cycles.
- Invariants the bench must assert every cycle:
  - gnt is zero or one-hot.
  - gnt == (en ? 1<<sel : 0).
  - Never more than one decoder line high.
  - No grant is issued to a requester whose req was low in the arbitration cycle.
- sel and en are unknown-free from reset onward.

Test Plan:
- Single request: after reset, req=4'b0100 held for 3 cycles then dropped → gnt=4'b0100, sel=2, en=1 from the cycle after req rises, for 3 cycles; then one GAP cycle with busy=1; then IDLE; expired never pulses.
- Full contention: HOLD_MAX=2, req=4'b1111 held constant → grant order 0,1,2,3,0; each grant is 2 cycles followed by 1 GAP cycle; expired pulses in every GAP.
- Wrap-around: ptr=3 after a grant to 2, req=4'b0011 → grant goes to 0, then 1, then 0.
- Release beats expiry: HOLD_MAX=3, req[1] falls in the third GRANT cycle → GAP entered with expired=0, ptr=2.
- Reset mid-grant: rst_n pulled low during a GRANT to requester 2 → en, gnt, busy go to 0 immediately without waiting for a clock edge; after release with req=4'b1100, the first grant is to 2 because ptr=0.
- Sole requester re-grant: HOLD_MAX=4, only req[3] held high for 10 cycles → GRANT(4), GAP, GRANT(4), GAP, GRANT(…), with sel=3 throughout; en is low only in GAP cycles.
